flot_add_pipe: RTL and testbench

FLOT_ADD_PIPE -- requirements
Module: flot_add_pipe

---
 rtl/flot_add_pipe_if.sv | 33 +++
 rtl/flot_add_pipe.sv | 183 ++++++++++++++++++
 tb/tb_flot_add_pipe.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/flot_add_pipe_if.sv
// Operand/result bus for the pipelined floating-point adder.
// Valid/ready: a beat moves on a rising edge only when its valid and ready are
// both high; the source keeps payload and valid stable until that edge, and
// ready may depend on valid in the same cycle but never the other way round.
interface flot_add_pipe_if #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rnd;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         ovf;
    logic         zero;

    // Adder side
    modport slave (
        input  in_valid, a, b, rnd, out_ready,
        output in_ready, out_valid, out, ovf, zero
    );

    // Producer/consumer side
    modport master (
        output in_valid, a, b, rnd, out_ready,
        input  in_ready, out_valid, out, ovf, zero
    );
endinterface

// File: rtl/flot_add_pipe.sv
// Three-stage sign-magnitude floating-point adder with truncate or
// round-to-nearest-even, denormal support and saturation on overflow.
// S1 orders and aligns, S2 adds/subtracts, S3 normalises, rounds, saturates.
// The whole pipeline moves as one: it advances when the output slot is empty
// or being drained, so bubbles stay where they are.
module flot_add_pipe #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    flot_add_pipe_if.slave bus
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int F    = MAN_W + 4;          // {hidden, man, G, R, S}
    localparam int XW   = EXP_W + 2;          // headroom for carry and round-up
    localparam int EMAX = (1 << EXP_W) - 1;

    logic advance;
    assign advance      = !bus.out_valid | bus.out_ready;
    assign bus.in_ready = advance;

    // ------------------------------------------------------------------ S1
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    assign {sa, ea, fa} = bus.a;
    assign {sb, eb, fb} = bus.b;

    logic [EXP_W-1:0] ea_eff, eb_eff, big_e, sm_e, diff, sh1;
    logic [MAN_W:0]   ma, mb, big_m, sm_m;
    logic             a_ge_b, big_s, collapse;
    logic [F-1:0]     sm_f;
    logic [2*F-2:0]   wide;
    logic [F-1:0]     s1_big_d, s1_small_d;
    logic             s1_sign_d, s1_sub_d;

    // Unpack, put the larger magnitude first, align the smaller into G/R/S.
    always_comb begin
        ea_eff   = (ea == '0) ? EXP_W'(1) : ea;
        eb_eff   = (eb == '0) ? EXP_W'(1) : eb;
        ma       = {ea != '0, fa};
        mb       = {eb != '0, fb};
        a_ge_b   = {ea_eff, ma} >= {eb_eff, mb};
        big_e    = a_ge_b ? ea_eff : eb_eff;
        big_m    = a_ge_b ? ma : mb;
        big_s    = a_ge_b ? sa : sb;
        sm_e     = a_ge_b ? eb_eff : ea_eff;
        sm_m     = a_ge_b ? mb : ma;
        diff     = big_e - sm_e;
        // Shifts this far leave nothing but sticky, so the shifter never
        // sees an amount wider than the field.
        collapse = int'(diff) >= F - 1;
        sh1      = collapse ? '0 : diff;
        sm_f     = {sm_m, 3'b000};
        wide     = {sm_f, {(F-1){1'b0}}} >> sh1;
        if (collapse) begin
            s1_small_d = {{(F-1){1'b0}}, |sm_m};
        end else begin
            s1_small_d = {wide[2*F-2:F], wide[F-1] | (|wide[F-2:0])};
        end
        s1_big_d  = {big_m, 3'b000};
        s1_sign_d = big_s;
        s1_sub_d  = sa ^ sb;
    end

    logic             s1_valid_q, s1_sign_q, s1_sub_q, s1_rnd_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [F-1:0]     s1_big_q, s1_small_q;

    // ------------------------------------------------------------------ S2
    logic [F:0] s2_sum_d;

    // Larger minus smaller never goes negative, so one extra bit holds carry.
    always_comb begin
        if (s1_sub_q) s2_sum_d = {1'b0, s1_big_q} - {1'b0, s1_small_q};
        else          s2_sum_d = {1'b0, s1_big_q} + {1'b0, s1_small_q};
    end

    logic             s2_valid_q, s2_sign_q, s2_rnd_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [F:0]       s2_sum_q;

    // ------------------------------------------------------------------ S3
    function automatic int clz(input logic [F-1:0] v);
        int n;
        n = F;
        for (int i = 0; i < F; i++) begin
            if (v[i]) n = F - 1 - i;
        end
        return n;
    endfunction

    logic [XW-1:0]    e3;
    logic [F-1:0]     f3;
    int               lz3, sh3;
    logic [MAN_W:0]   man3, mann3;
    logic [MAN_W+1:0] manr3;
    logic             inc3, ovf3, zero3;
    logic [W-1:0]     out3;

    // Normalise (right on carry, left down to exponent 1), round, saturate.
    always_comb begin
        e3  = {2'b00, s2_exp_q};
        f3  = s2_sum_q[F-1:0];
        lz3 = 0;
        sh3 = 0;
        if (s2_sum_q[F]) begin
            f3 = {s2_sum_q[F:2], s2_sum_q[1] | s2_sum_q[0]};
            e3 = e3 + XW'(1);
        end else begin
            lz3 = clz(f3);
            sh3 = (lz3 < int'(e3) - 1) ? lz3 : int'(e3) - 1;
            f3  = f3 << sh3;
            e3  = e3 - XW'(sh3);
        end
        man3  = f3[F-1:3];
        inc3  = s2_rnd_q & f3[2] & (f3[1] | f3[0] | man3[0]);
        manr3 = {1'b0, man3} + {{(MAN_W+1){1'b0}}, inc3};
        if (manr3[MAN_W+1]) begin
            mann3 = manr3[MAN_W+1:1];
            e3    = e3 + XW'(1);
        end else begin
            mann3 = manr3[MAN_W:0];
        end
        ovf3  = e3 > XW'(EMAX);
        zero3 = !ovf3 && (mann3 == '0);
        if (ovf3) begin
            out3 = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
        end else if (zero3) begin
            out3 = '0;
        end else begin
            // A hidden bit of 0 can only remain at exponent 1: encode denormal.
            out3 = {s2_sign_q, mann3[MAN_W] ? e3[EXP_W-1:0] : {EXP_W{1'b0}},
                    mann3[MAN_W-1:0]};
        end
    end

    logic         out_valid_q, ovf_q, zero_q;
    logic [W-1:0] out_q;

    // Stage valid bits and the output register; reset drops everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (advance) begin
            s1_valid_q  <= bus.in_valid;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_q  <= out3;
                ovf_q  <= ovf3;
                zero_q <= zero3;
            end
        end
    end

    // Data path registers; only meaningful alongside their valid bit.
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_sign_q  <= s1_sign_d;
            s1_sub_q   <= s1_sub_d;
            s1_rnd_q   <= bus.rnd;
            s1_exp_q   <= big_e;
            s1_big_q   <= s1_big_d;
            s1_small_q <= s1_small_d;
            s2_sign_q  <= s1_sign_q;
            s2_rnd_q   <= s1_rnd_q;
            s2_exp_q   <= s1_exp_q;
            s2_sum_q   <= s2_sum_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_flot_add_pipe.sv
// Directed bench for flot_add_pipe (EXP_W=3, MAN_W=4).
// Expected words are packed {ovf, zero, out}.
module tb_flot_add_pipe;
    localparam int EXP_W = 3;
    localparam int MAN_W = 4;
    localparam int W     = 1 + EXP_W + MAN_W;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    flot_add_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus();

    flot_add_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [W+1:0] exp_q[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver: present one pair, count edges until out_valid (bounded)
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic r,
                          output logic [W+1:0] res, output int lat);
        bus.a         = a;
        bus.b         = b;
        bus.rnd       = r;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            lat++;
        end while (!bus.out_valid && lat < 10);
        res = {bus.ovf, bus.zero, bus.out};
    endtask

    task automatic drain;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.rnd       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); bad++; end
        total++; if (bus.out !== '0) begin $display("FAIL reset_out: got %b required 0", bus.out); bad++; end
        total++; if (bus.ovf !== 1'b0) begin $display("FAIL reset_ovf: got %b required 0", bus.ovf); bad++; end
        total++; if (bus.zero !== 1'b0) begin $display("FAIL reset_zero: got %b required 0", bus.zero); bad++; end
        rst_n = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); bad++; end
        @(posedge clk); #1;
    endtask

    task automatic test_add_sub;
        logic [W-1:0] va[7] = '{8'b0_011_0000, 8'b1_011_0000, 8'b0_011_1000, 8'b0_101_0110,
                                8'b1_011_0000, 8'b1_101_0110, 8'b0_001_0000};
        logic [W-1:0] vb[7] = '{8'b0_011_0000, 8'b1_011_0000, 8'b1_011_0000, 8'b1_101_0110,
                                8'b0_010_0000, 8'b0_101_0110, 8'b1_000_1000};
        logic [W+1:0] ve[7] = '{10'b0_0_0_100_0000, 10'b0_0_1_100_0000, 10'b0_0_0_010_0000,
                                10'b0_1_0_000_0000, 10'b0_0_1_010_0000, 10'b0_1_0_000_0000,
                                10'b0_0_0_000_1000};
        logic [W+1:0] res;
        int lat;
        for (int i = 0; i < 7; i++) begin
            run_op(va[i], vb[i], 1'b0, res, lat);
            total++; if (res !== ve[i]) begin $display("FAIL add_sub[%0d]: got %b required %b", i, res, ve[i]); bad++; end
            total++; if (lat !== 3) begin $display("FAIL add_sub_latency[%0d]: got %0d required 3", i, lat); bad++; end
        end
    endtask

    task automatic test_round;
        logic [W-1:0] va[7] = '{8'b0_011_0001, 8'b0_011_0001, 8'b0_011_1111, 8'b0_011_1111,
                                8'b0_011_0000, 8'b0_111_0000, 8'b0_111_0000};
        logic [W-1:0] vb[7] = '{8'b0_010_0001, 8'b0_010_0001, 8'b0_000_0010, 8'b0_000_0010,
                                8'b0_000_0010, 8'b0_010_1100, 8'b0_010_1100};
        logic         vr[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [W+1:0] ve[7] = '{10'b0_0_0_011_1001, 10'b0_0_0_011_1010, 10'b0_0_0_011_1111,
                                10'b0_0_0_100_0000, 10'b0_0_0_011_0000, 10'b0_0_0_111_0000,
                                10'b0_0_0_111_0001};
        logic [W+1:0] res;
        int lat;
        for (int i = 0; i < 7; i++) begin
            run_op(va[i], vb[i], vr[i], res, lat);
            total++; if (res !== ve[i]) begin $display("FAIL round[%0d]: got %b required %b", i, res, ve[i]); bad++; end
            total++; if (lat !== 3) begin $display("FAIL round_latency[%0d]: got %0d required 3", i, lat); bad++; end
        end
    endtask

    task automatic test_boundary;
        logic [W-1:0] va[7] = '{8'b0_111_1111, 8'b1_111_1111, 8'b0_111_1111, 8'b0_111_1111,
                                8'b0_000_1000, 8'b0_000_0000, 8'b0_000_0011};
        logic [W-1:0] vb[7] = '{8'b0_111_1111, 8'b1_111_1111, 8'b0_010_0000, 8'b0_010_0000,
                                8'b0_000_1000, 8'b1_000_0000, 8'b0_000_0100};
        logic         vr[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [W+1:0] ve[7] = '{10'b1_0_0_111_1111, 10'b1_0_1_111_1111, 10'b0_0_0_111_1111,
                                10'b1_0_0_111_1111, 10'b0_0_0_001_0000, 10'b0_1_0_000_0000,
                                10'b0_0_0_000_0111};
        logic [W+1:0] res;
        int lat;
        for (int i = 0; i < 7; i++) begin
            run_op(va[i], vb[i], vr[i], res, lat);
            total++; if (res !== ve[i]) begin $display("FAIL boundary[%0d]: got %b required %b", i, res, ve[i]); bad++; end
            total++; if (lat !== 3) begin $display("FAIL boundary_latency[%0d]: got %0d required 3", i, lat); bad++; end
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] va[5] = '{8'b0_011_0000, 8'b0_011_1000, 8'b0_101_0110, 8'b0_111_1111, 8'b0_000_1000};
        logic [W-1:0] vb[5] = '{8'b0_011_0000, 8'b1_011_0000, 8'b1_101_0110, 8'b0_111_1111, 8'b0_000_1000};
        logic [W+1:0] ve[5] = '{10'b0_0_0_100_0000, 10'b0_0_0_010_0000, 10'b0_1_0_000_0000,
                                10'b1_0_0_111_1111, 10'b0_0_0_001_0000};
        logic [W+1:0] e;
        int sent = 0, got = 0, stalls = 0;
        drain();
        exp_q.delete();
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            bus.in_valid = (sent < 5);
            if (sent < 5) begin
                bus.a = va[sent];
                bus.b = vb[sent];
            end
            bus.rnd       = 1'b0;
            bus.out_ready = !(cyc >= 3 && cyc < 7);
            #1;
            if (bus.out_valid && !bus.out_ready) begin
                stalls++;
                total++; if (bus.in_ready !== 1'b0) begin $display("FAIL stall_in_ready[cyc %0d]: got %b required 0", cyc, bus.in_ready); bad++; end
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stall_hold[cyc %0d]: got %b required nothing valid", cyc, {bus.ovf, bus.zero, bus.out}); bad++;
                end else if ({bus.ovf, bus.zero, bus.out} !== exp_q[0]) begin
                    $display("FAIL stall_hold[cyc %0d]: got %b required %b", cyc, {bus.ovf, bus.zero, bus.out}, exp_q[0]); bad++;
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stream_extra[cyc %0d]: got %b required no result", cyc, {bus.ovf, bus.zero, bus.out}); bad++;
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.ovf, bus.zero, bus.out} !== e) begin
                        $display("FAIL stream_data[%0d]: got %b required %b", got, {bus.ovf, bus.zero, bus.out}, e); bad++;
                    end
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ve[sent]);
                sent++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        total++; if (got !== 5) begin $display("FAIL stream_count: got %0d required 5", got); bad++; end
        total++; if (stalls !== 4) begin $display("FAIL stream_stalls: got %0d required 4", stalls); bad++; end
        total++; if (exp_q.size() !== 0) begin $display("FAIL stream_pending: got %0d required 0", exp_q.size()); bad++; end
        total++; if (bus.out_valid !== 1'b0) begin $display("FAIL stream_dup: got out_valid=%b required 0", bus.out_valid); bad++; end
    endtask

    task automatic test_reset_in_flight;
        logic [W+1:0] res;
        int lat;
        int stale = 0;
        drain();
        bus.a = 8'b0_111_1111; bus.b = 8'b0_111_1111; bus.rnd = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.a = 8'b0_011_0001; bus.b = 8'b0_010_0001;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.out_valid !== 1'b1) begin $display("FAIL flight_pre_valid: got %b required 1", bus.out_valid); bad++; end
        rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin $display("FAIL flight_rst_valid: got %b required 0", bus.out_valid); bad++; end
        total++; if (bus.out !== '0) begin $display("FAIL flight_rst_out: got %b required 0", bus.out); bad++; end
        total++; if (bus.ovf !== 1'b0) begin $display("FAIL flight_rst_ovf: got %b required 0", bus.ovf); bad++; end
        total++; if (bus.zero !== 1'b0) begin $display("FAIL flight_rst_zero: got %b required 0", bus.zero); bad++; end
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            total++; if (bus.out_valid !== 1'b0) begin $display("FAIL flight_stale[%0d]: got out_valid=%b required 0", i, bus.out_valid); bad++; stale++; end
        end
        run_op(8'b0_011_0000, 8'b0_011_0000, 1'b0, res, lat);
        total++; if (res !== 10'b0_0_0_100_0000) begin $display("FAIL flight_new: got %b required %b", res, 10'b0_0_0_100_0000); bad++; end
        total++; if (lat !== 3) begin $display("FAIL flight_new_latency: got %0d required 3", lat); bad++; end
        drain();
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_round();
        test_boundary();
        test_back_to_back();
        test_reset_in_flight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
